// File: rtl/islem_denetleyici_if.sv
// Bus between the operation controller, its arithmetic units and the request/result ports.
// master is the controller side; slave is the requester/unit/consumer side.
interface islem_denetleyici_if #(
  parameter int unsigned SAYAC_GENISLIK = 16
);
  logic                      istek_gecerli;
  logic                      istek_hazir;
  logic [31:0]               sayi1;
  logic [31:0]               sayi2;
  logic [2:0]                tur;
  logic [31:0]               birim_sayi1;
  logic [31:0]               birim_sayi2;
  logic [6:0]                birim_baslat;
  logic [447:0]              birim_sonuc;
  logic [6:0]                birim_hazir;
  logic [6:0]                birim_gecerli;
  logic [6:0]                birim_tasma;
  logic [63:0]               sonuc;
  logic                      gecerli;
  logic                      tasma;
  logic                      hata;
  logic                      cikis_gecerli;
  logic                      cikis_hazir;
  logic [SAYAC_GENISLIK-1:0] islem_sayaci;

  modport master (
    input  istek_gecerli, sayi1, sayi2, tur, birim_sonuc, birim_hazir, birim_gecerli,
           birim_tasma, cikis_hazir,
    output istek_hazir, birim_sayi1, birim_sayi2, birim_baslat, sonuc, gecerli, tasma, hata,
           cikis_gecerli, islem_sayaci
  );

  modport slave (
    output istek_gecerli, sayi1, sayi2, tur, birim_sonuc, birim_hazir, birim_gecerli,
           birim_tasma, cikis_hazir,
    input  istek_hazir, birim_sayi1, birim_sayi2, birim_baslat, sonuc, gecerli, tasma, hata,
           cikis_gecerli, islem_sayaci
  );
endinterface

// File: rtl/islem_denetleyici.sv
// Operation controller: accepts one request, pulses the selected unit's start, waits for its
// done handshake (falling then rising hazir, with timeout) and holds the result until taken.
module islem_denetleyici #(
  parameter int unsigned ZAMAN_ASIMI    = 255,
  parameter int unsigned SAYAC_GENISLIK = 16
) (
  input logic                 clk,
  input logic                 rst,
  islem_denetleyici_if.master bus
);
  localparam logic [2:0]                TurGecersiz = 3'b111;
  localparam logic [7:0]                ZamanSon    = 8'(ZAMAN_ASIMI - 1);
  localparam logic [SAYAC_GENISLIK-1:0] SayacBir    = 1;

  typedef enum logic [2:0] {Bos, Baslat, BekleDus, BekleYuk, Sonuc} durum_t;

  durum_t                    durum_q;
  logic [2:0]                tur_q;
  logic [31:0]               sayi1_q;
  logic [31:0]               sayi2_q;
  logic [6:0]                baslat_q;
  logic [63:0]               sonuc_q;
  logic                      gecerli_q;
  logic                      tasma_q;
  logic                      hata_q;
  logic [7:0]                zaman_q;
  logic [SAYAC_GENISLIK-1:0] sayac_q;

  // Padded to eight units so a select of 7 never indexes past the vector.
  logic [7:0]   hazir_ext;
  logic [7:0]   gecerli_ext;
  logic [7:0]   tasma_ext;
  logic [511:0] sonuc_ext;
  logic         secili_hazir;

  assign hazir_ext    = {1'b0, bus.birim_hazir};
  assign gecerli_ext  = {1'b0, bus.birim_gecerli};
  assign tasma_ext    = {1'b0, bus.birim_tasma};
  assign sonuc_ext    = {64'd0, bus.birim_sonuc};
  assign secili_hazir = hazir_ext[tur_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum_q   <= Bos;
      tur_q     <= '0;
      sayi1_q   <= '0;
      sayi2_q   <= '0;
      baslat_q  <= '0;
      sonuc_q   <= '0;
      gecerli_q <= 1'b0;
      tasma_q   <= 1'b0;
      hata_q    <= 1'b0;
      zaman_q   <= '0;
      sayac_q   <= '0;
    end else begin
      baslat_q <= '0;
      unique case (durum_q)
        Bos: begin
          if (bus.istek_gecerli) begin
            sayi1_q <= bus.sayi1;
            sayi2_q <= bus.sayi2;
            tur_q   <= bus.tur;
            if (bus.tur == TurGecersiz) begin
              sonuc_q   <= '0;
              gecerli_q <= 1'b0;
              tasma_q   <= 1'b0;
              hata_q    <= 1'b1;
              durum_q   <= Sonuc;
            end else begin
              baslat_q <= 7'd1 << bus.tur;
              durum_q  <= Baslat;
            end
          end
        end
        Baslat: begin
          zaman_q <= '0;
          durum_q <= BekleDus;
        end
        BekleDus, BekleYuk: begin
          zaman_q <= zaman_q + 8'd1;
          // Completion is checked first so it wins over a same-cycle timeout.
          if (durum_q == BekleYuk && secili_hazir) begin
            sonuc_q   <= sonuc_ext[{tur_q, 6'd0} +: 64];
            gecerli_q <= gecerli_ext[tur_q];
            tasma_q   <= tasma_ext[tur_q];
            hata_q    <= 1'b0;
            durum_q   <= Sonuc;
          end else if (zaman_q == ZamanSon) begin
            sonuc_q   <= '0;
            gecerli_q <= 1'b0;
            tasma_q   <= 1'b0;
            hata_q    <= 1'b1;
            durum_q   <= Sonuc;
          end else if (durum_q == BekleDus && !secili_hazir) begin
            durum_q <= BekleYuk;
          end
        end
        Sonuc: begin
          if (bus.cikis_hazir) begin
            sayac_q <= sayac_q + SayacBir;
            durum_q <= Bos;
          end
        end
        default: durum_q <= Bos;
      endcase
    end
  end

  assign bus.istek_hazir   = (durum_q == Bos);
  assign bus.cikis_gecerli = (durum_q == Sonuc);
  assign bus.birim_sayi1   = sayi1_q;
  assign bus.birim_sayi2   = sayi2_q;
  assign bus.birim_baslat  = baslat_q;
  assign bus.sonuc         = sonuc_q;
  assign bus.gecerli       = gecerli_q;
  assign bus.tasma         = tasma_q;
  assign bus.hata          = hata_q;
  assign bus.islem_sayaci  = sayac_q;

endmodule

// File: tb/tb_islem_denetleyici.sv
// Bench for islem_denetleyici: vector table with unit stubs, result scoreboard, plus
// backpressure, mid-operation reset and counter wrap sequences.
module tb_islem_denetleyici;
  logic clk;
  logic rst;

  islem_denetleyici_if #(.SAYAC_GENISLIK(4)) bif ();

  islem_denetleyici #(
    .ZAMAN_ASIMI   (8),
    .SAYAC_GENISLIK(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  tur;
    int          dus;
    int          yuk;
    int          bp;
    logic [63:0] sonuc;
    logic        gecerli;
    logic        tasma;
    logic        hata;
    int          gecikme;
  } vek_t;

  typedef struct {
    logic [63:0] sonuc;
    logic        gecerli;
    logic        tasma;
    logic        hata;
  } beklenen_t;

  beklenen_t  sb[$];
  int         toplam = 0;
  int         kotu = 0;
  logic [3:0] exp_sayac = '0;
  bit         sayac_bak = 0;
  int         dus_ayar = 1;
  int         yuk_ayar = 1;
  int         ctr[7] = '{default: -1};
  int         s_dus[7];
  int         s_yuk[7];

  task automatic kontrol(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
    toplam++;
    if (gercek !== beklenen) begin
      kotu++;
      $display("FAIL %s: got %h expected %h", ad, gercek, beklenen);
    end
  endtask

  task automatic hata_bildir(input string ad);
    toplam++;
    kotu++;
    $display("FAIL %s: got timeout/unexpected expected event", ad);
  endtask

  // Behaviour of the arithmetic units: {gecerli, tasma, sonuc}.
  function automatic logic [65:0] birim_model(input int u, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [32:0] t;
    case (u)
      0: begin
        t = {1'b0, a} + {1'b0, b};
        return {1'b1, t[32], 32'd0, t[31:0]};
      end
      1: return {1'b1, a < b, 32'd0, a - b};
      2: return {1'b1, 1'b0, {32'd0, a} * {32'd0, b}};
      3: begin
        if (b == 32'd0) return {1'b0, 1'b0, 64'd0};
        return {1'b1, 1'b0, 32'd0, a / b};
      end
      default: return {1'b1, 1'b0, 32'(u), a ^ b};
    endcase
  endfunction

  // Unit stubs: idle units show random noise; a started unit keeps hazir high, drops it
  // dus cycles after start and raises it with the result yuk cycles after that.
  always @(negedge clk) begin
    logic [447:0] s;
    logic [6:0]   hz;
    logic [6:0]   gc;
    logic [6:0]   ts;
    logic [65:0]  r;
    s  = bif.birim_sonuc;
    hz = bif.birim_hazir;
    gc = bif.birim_gecerli;
    ts = bif.birim_tasma;
    for (int i = 0; i < 7; i++) begin
      if (bif.birim_baslat[i]) begin
        ctr[i]   = 0;
        s_dus[i] = dus_ayar;
        s_yuk[i] = yuk_ayar;
        hz[i]    = 1'b1;
      end else if (ctr[i] == -1) begin
        hz[i] = 1'($urandom);
        gc[i] = 1'($urandom);
        ts[i] = 1'($urandom);
        s[64*i +: 64] = {$urandom, $urandom};
      end else if (ctr[i] == -2) begin
        ctr[i] = -1;
      end else begin
        ctr[i]++;
        if (ctr[i] == s_dus[i]) hz[i] = 1'b0;
        if (ctr[i] == s_dus[i] + s_yuk[i]) begin
          r = birim_model(i, bif.birim_sayi1, bif.birim_sayi2);
          hz[i] = 1'b1;
          gc[i] = r[65];
          ts[i] = r[64];
          s[64*i +: 64] = r[63:0];
          ctr[i] = -2;
        end
      end
    end
    bif.birim_sonuc   = s;
    bif.birim_hazir   = hz;
    bif.birim_gecerli = gc;
    bif.birim_tasma   = ts;
  end

  // Scoreboard: pops on each output handshake and checks the counter one cycle later.
  always begin
    beklenen_t e;
    @(negedge clk);
    #2;
    if (sayac_bak) begin
      sayac_bak = 0;
      kontrol("islem_sayaci", 64'(bif.islem_sayaci), 64'(exp_sayac));
    end
    if (bif.cikis_gecerli && bif.cikis_hazir) begin
      if (sb.size() == 0) begin
        hata_bildir("unexpected output handshake");
      end else begin
        e = sb.pop_front();
        kontrol("sonuc", bif.sonuc, e.sonuc);
        kontrol("gecerli", 64'(bif.gecerli), 64'(e.gecerli));
        kontrol("tasma", 64'(bif.tasma), 64'(e.tasma));
        kontrol("hata", 64'(bif.hata), 64'(e.hata));
      end
      exp_sayac = exp_sayac + 4'd1;
      sayac_bak = 1;
    end
  end

  task automatic bos_bekle();
    int k;
    k = 0;
    while (!bif.istek_hazir && k < 50) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic islem(input vek_t v);
    int        k;
    bit        bitti;
    beklenen_t e;
    bos_bekle();
    if (!bif.istek_hazir) begin
      hata_bildir("wait for istek_hazir");
      return;
    end
    dus_ayar          = v.dus;
    yuk_ayar          = v.yuk;
    bif.sayi1         = v.a;
    bif.sayi2         = v.b;
    bif.tur           = v.tur;
    bif.istek_gecerli = 1'b1;
    bif.cikis_hazir   = (v.bp == 0);
    e.sonuc   = v.sonuc;
    e.gecerli = v.gecerli;
    e.tasma   = v.tasma;
    e.hata    = v.hata;
    sb.push_back(e);
    k = 0;
    bitti = 0;
    while (!bitti && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        bif.istek_gecerli = 1'b0;
        kontrol("birim_baslat pulse", 64'(bif.birim_baslat),
                64'((v.tur == 3'd7) ? 7'd0 : (7'd1 << v.tur)));
        kontrol("birim_sayi1", 64'(bif.birim_sayi1), 64'(v.a));
        kontrol("birim_sayi2", 64'(bif.birim_sayi2), 64'(v.b));
      end
      if (k == 2) kontrol("birim_baslat cleared", 64'(bif.birim_baslat), 64'd0);
      if (bif.cikis_gecerli) bitti = 1;
    end
    if (!bitti) begin
      hata_bildir("wait for cikis_gecerli");
      return;
    end
    kontrol("latency", 64'(k), 64'(v.gecikme));
    if (v.bp > 0) begin
      bif.istek_gecerli = 1'b1;
      bif.sayi1         = 32'hDEAD_BEEF;
      bif.sayi2         = 32'h0000_0001;
      bif.tur           = 3'd1;
      for (int j = 0; j < v.bp; j++) begin
        @(negedge clk);
        kontrol("bp sonuc stable", bif.sonuc, v.sonuc);
        kontrol("bp cikis_gecerli", 64'(bif.cikis_gecerli), 64'd1);
        kontrol("bp istek_hazir", 64'(bif.istek_hazir), 64'd0);
        kontrol("bp islem_sayaci", 64'(bif.islem_sayaci), 64'(exp_sayac));
      end
      bif.istek_gecerli = 1'b0;
      bif.cikis_hazir   = 1'b1;
      @(negedge clk);
      kontrol("bp dropped request", 64'(bif.birim_sayi1), 64'(v.a));
      kontrol("bp back to idle", 64'(bif.istek_hazir), 64'd1);
    end
  endtask

  vek_t tablo[13];

  initial begin
    vek_t v;
    bit   gordu;

    tablo[0]  = '{32'd5, 32'd7, 3'd0, 1, 3, 0, 64'd12, 1'b1, 1'b0, 1'b0, 6};
    tablo[1]  = '{32'd9, 32'd9, 3'd7, 1, 1, 0, 64'd0, 1'b0, 1'b0, 1'b1, 1};
    tablo[2]  = '{32'd10, 32'd3, 3'd1, 1, 1, 0, 64'd7, 1'b1, 1'b0, 1'b0, 4};
    tablo[3]  = '{32'd3, 32'd10, 3'd1, 1, 1, 0, 64'h0000_0000_FFFF_FFF9, 1'b1, 1'b1, 1'b0, 4};
    tablo[4]  = '{32'hFFFF_FFFF, 32'd2, 3'd0, 2, 1, 0, 64'd1, 1'b1, 1'b1, 1'b0, 5};
    tablo[5]  = '{32'h0001_0000, 32'h0001_0000, 3'd2, 3, 2, 0, 64'h0000_0001_0000_0000,
                  1'b1, 1'b0, 1'b0, 7};
    tablo[6]  = '{32'd100, 32'd7, 3'd3, 1, 7, 0, 64'd14, 1'b1, 1'b0, 1'b0, 10};
    tablo[7]  = '{32'd5, 32'd0, 3'd3, 1, 1, 0, 64'd0, 1'b0, 1'b0, 1'b0, 4};
    tablo[8]  = '{32'd20, 32'd30, 3'd4, 1, 1000, 0, 64'd0, 1'b0, 1'b0, 1'b1, 10};
    tablo[9]  = '{32'h1234_5678, 32'h0F0F_0F0F, 3'd5, 1, 1, 0, 64'h0000_0005_1D3B_5977,
                  1'b1, 1'b0, 1'b0, 4};
    tablo[10] = '{32'hFFFF_0000, 32'h0000_FFFF, 3'd6, 1, 8, 0, 64'd0, 1'b0, 1'b0, 1'b1, 10};
    tablo[11] = '{32'd1, 32'd1, 3'd0, 1000, 1, 0, 64'd0, 1'b0, 1'b0, 1'b1, 10};
    tablo[12] = '{32'd1, 32'd2, 3'd0, 1, 1, 5, 64'd3, 1'b1, 1'b0, 1'b0, 4};

    bif.istek_gecerli = 1'b0;
    bif.sayi1         = '0;
    bif.sayi2         = '0;
    bif.tur           = '0;
    bif.cikis_hazir   = 1'b1;
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    kontrol("reset istek_hazir", 64'(bif.istek_hazir), 64'd1);
    kontrol("reset cikis_gecerli", 64'(bif.cikis_gecerli), 64'd0);
    kontrol("reset birim_baslat", 64'(bif.birim_baslat), 64'd0);
    kontrol("reset sonuc", bif.sonuc, 64'd0);
    kontrol("reset hata", 64'(bif.hata), 64'd0);
    kontrol("reset islem_sayaci", 64'(bif.islem_sayaci), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) islem(tablo[i]);

    // Reset while unit 3 is being waited on; its later completion must be ignored.
    bos_bekle();
    dus_ayar          = 1;
    yuk_ayar          = 6;
    bif.sayi1         = 32'd100;
    bif.sayi2         = 32'd7;
    bif.tur           = 3'd3;
    bif.istek_gecerli = 1'b1;
    bif.cikis_hazir   = 1'b1;
    @(negedge clk);
    bif.istek_gecerli = 1'b0;
    repeat (2) @(negedge clk);
    kontrol("busy before reset", 64'(bif.istek_hazir), 64'd0);
    #3 rst = 1'b0;
    #1;
    kontrol("async reset cikis_gecerli", 64'(bif.cikis_gecerli), 64'd0);
    kontrol("async reset istek_hazir", 64'(bif.istek_hazir), 64'd1);
    kontrol("async reset birim_baslat", 64'(bif.birim_baslat), 64'd0);
    kontrol("async reset sonuc", bif.sonuc, 64'd0);
    kontrol("async reset birim_sayi1", 64'(bif.birim_sayi1), 64'd0);
    kontrol("async reset islem_sayaci", 64'(bif.islem_sayaci), 64'd0);
    sb.delete();
    exp_sayac = '0;
    @(negedge clk);
    rst = 1'b1;
    gordu = 0;
    repeat (12) begin
      @(negedge clk);
      if (bif.cikis_gecerli) gordu = 1;
    end
    kontrol("no output after reset", 64'(gordu), 64'd0);

    // Seventeen completions on a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      v.a       = 32'(i);
      v.b       = 32'd100;
      v.tur     = (i % 2 == 1) ? 3'd2 : 3'd0;
      v.dus     = 1;
      v.yuk     = 1;
      v.bp      = 0;
      v.sonuc   = (i % 2 == 1) ? 64'(i * 100) : 64'(i + 100);
      v.gecerli = 1'b1;
      v.tasma   = 1'b0;
      v.hata    = 1'b0;
      v.gecikme = 4;
      islem(v);
    end
    @(negedge clk);
    kontrol("counter wrap", 64'(bif.islem_sayaci), 64'd1);
    @(negedge clk);
    if (sb.size() != 0) hata_bildir("scoreboard not drained");

    $display("test done: total=%0d bad=%0d", toplam, kotu);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/islem_denetleyici.md
ISLEM_DENETLEYICI -- requirements
Module: islem_denetleyici

Interface
REQ-001 Parameter ZAMAN_ASIMI, default 255, max cycles waited for a unit result before abort (1..255).
REQ-002 Parameter SAYAC_GENISLIK, default 16, width of completed-operation counter.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 istek_gecerli  in  1  request valid.
REQ-006 istek_hazir  out  1  controller can accept request.
REQ-007 sayi1, sayi2  in  32 each  operands.
REQ-008 tur  in  3  op select: 000 add, 001 sub, 010 mul, 011 div, 100 sqrt, 101 tan, 110 cot, 111 illegal.
REQ-009 birim_sayi1, birim_sayi2  out  32 each  latched operands to all units.
REQ-010 birim_baslat  out  7  one-hot start pulse, bit i = unit i.
REQ-011 birim_sonuc  in  448  unit results, unit i at bits [64i+63:64i].
REQ-012 birim_hazir, birim_gecerli, birim_tasma  in  7 each  per-unit done/valid/overflow.
REQ-013 sonuc  out  64  captured result.
REQ-014 gecerli, tasma, hata  out  1 each  captured valid, overflow, controller error.
REQ-015 cikis_gecerli  out  1  result valid; cikis_hazir  in  1  downstream ready.
REQ-016 islem_sayaci  out  SAYAC_GENISLIK  count of completed output handshakes.

Function
REQ-017 FSM states SHALL be BOS, BASLAT, BEKLE_DUS, BEKLE_YUK, SONUC; istek_hazir=1 only in BOS, cikis_gecerli=1 only in SONUC.
REQ-018 BOS: on istek_gecerli&istek_hazir, latch sayi1, sayi2, tur; tur!=111 -> BASLAT; tur=111 -> SONUC with sonuc=0, gecerli=0, tasma=0, hata=1.
REQ-019 Requests while istek_hazir=0 SHALL be ignored and not stored.
REQ-020 birim_sayi1/2 SHALL hold latched operands from accept until next accept.
REQ-021 BASLAT: birim_baslat[tur]=1 for exactly one cycle, all other bits 0, timeout counter cleared -> BEKLE_DUS.
REQ-022 BEKLE_DUS: birim_hazir[tur]=0 -> BEKLE_YUK; stale high hazir SHALL NOT complete the operation.
REQ-023 BEKLE_YUK: birim_hazir[tur]=1 -> capture birim_sonuc slice, birim_gecerli[tur], birim_tasma[tur], hata=0 -> SONUC.
REQ-024 Timeout counter SHALL increment each cycle in BEKLE_DUS/BEKLE_YUK; on reaching ZAMAN_ASIMI -> SONUC with sonuc=0, gecerli=0, tasma=0, hata=1.
REQ-025 Completion and timeout in the same cycle: completion SHALL win.
REQ-026 Only unit tur is observed; other units' signals SHALL be ignored.
REQ-027 SONUC: sonuc/gecerli/tasma/hata held stable; on cikis_hazir=1 -> BOS and islem_sayaci+1 at that edge.
REQ-028 islem_sayaci SHALL wrap from all-ones to 0.
REQ-029 cikis_hazir outside SONUC SHALL have no effect.
REQ-030 Latency: accept edge -> baslat next cycle; illegal tur -> cikis_gecerli one cycle after accept; earliest legal completion -> cikis_gecerli 4 cycles after accept.
REQ-031 Back-to-back: new request accepted no earlier than the cycle after output handshake.

Reset
REQ-032 rst=0 SHALL immediately force state BOS, birim_baslat=0, sonuc=0, gecerli=0, tasma=0, hata=0, cikis_gecerli=0, islem_sayaci=0, latched operands and tur=0, timeout counter=0.
REQ-033 istek_hazir SHALL be 1 while in reset and after release.
REQ-034 Reset mid-operation SHALL abandon the op; later unit hazir SHALL be ignored until a new start.

Verification
REQ-035 Add: sayi1=5, sayi2=7, tur=000, stub drops hazir 1 cycle after start, raises 3 cycles later with 12 -> birim_baslat=0000001 one cycle, sonuc=12, gecerli=1, hata=0, islem_sayaci=1.
REQ-036 Illegal: tur=111 -> birim_baslat stays 0, cikis_gecerli one cycle after accept, sonuc=0, hata=1.
REQ-037 Timeout: ZAMAN_ASIMI=8, tur=100, unit 4 never raises hazir -> cikis_gecerli after 8 wait cycles, hata=1, gecerli=0.
REQ-038 Backpressure: cikis_hazir=0 for 5 cycles in SONUC, new request presented -> outputs stable, istek_hazir=0, request dropped, counter unchanged until handshake.
REQ-039 Reset in BEKLE_YUK with tur=011 -> all outputs reset asynchronously; later unit 3 hazir pulse -> no cikis_gecerli.
REQ-040 Wrap: SAYAC_GENISLIK=4, 17 completed ops -> islem_sayaci=1.
